layer_ctrl: RTL and testbench

LAYER_CTRL -- requirements
Module: layer_ctrl

---
 rtl/layer_ctrl.sv | 158 +++++++++++++++
 tb/tb_layer_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_ctrl.sv
// Layer sequencer for a DIM x DIM systolic array: per layer it clears the accumulators,
// feeds DIM rows, waits out the array drain and streams DIM result rows to writeback.
module layer_ctrl #(
  parameter int NUM_LAYERS = 3,
  parameter int DIM        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_layering,
  input  logic [2:0] mode,
  input  logic       wb_ready,
  output logic       layer_ctrl_busy,
  output logic       acc_clr,
  output logic       feed_en,
  output logic [3:0] feed_idx,
  output logic [3:0] layer_idx,
  output logic       wb_valid,
  output logic [3:0] wb_row,
  output logic       layer_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    WB    = 3'd4
  } state_t;

  localparam logic [2:0] MODE_LAYER = 3'd2;
  localparam logic [3:0] LAST_ROW   = 4'(DIM - 1);
  localparam logic [3:0] LAST_LAYER = 4'(NUM_LAYERS - 1);
  // The array needs 2*DIM-1 cycles after the last feed before all results are final.
  localparam logic [4:0] DRAIN_LAST = 5'(2 * DIM - 2);

  state_t     state_q, state_d;
  logic       busy_q, busy_d;
  logic       acc_clr_q, acc_clr_d;
  logic       feed_en_q, feed_en_d;
  logic [3:0] feed_idx_q, feed_idx_d;
  logic [3:0] layer_idx_q, layer_idx_d;
  logic       wb_valid_q, wb_valid_d;
  logic [3:0] wb_row_q, wb_row_d;
  logic       layer_done_q, layer_done_d;
  logic [4:0] drain_cnt_q, drain_cnt_d;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    acc_clr_d    = 1'b0;
    feed_en_d    = feed_en_q;
    feed_idx_d   = feed_idx_q;
    layer_idx_d  = layer_idx_q;
    wb_valid_d   = wb_valid_q;
    wb_row_d     = wb_row_q;
    layer_done_d = 1'b0;
    drain_cnt_d  = drain_cnt_q;

    case (state_q)
      IDLE: begin
        if (start_layering && (mode == MODE_LAYER)) begin
          state_d     = CLR;
          busy_d      = 1'b1;
          acc_clr_d   = 1'b1;
          layer_idx_d = 4'd0;
        end
      end
      CLR: begin
        state_d    = FEED;
        feed_en_d  = 1'b1;
        feed_idx_d = 4'd0;
      end
      FEED: begin
        if (feed_idx_q == LAST_ROW) begin
          state_d     = DRAIN;
          feed_en_d   = 1'b0;
          drain_cnt_d = 5'd0;
        end else begin
          feed_idx_d = feed_idx_q + 4'd1;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d    = WB;
          wb_valid_d = 1'b1;
          wb_row_d   = 4'd0;
        end else begin
          drain_cnt_d = drain_cnt_q + 5'd1;
        end
      end
      WB: begin
        if (wb_ready) begin
          if (wb_row_q == LAST_ROW) begin
            wb_valid_d   = 1'b0;
            layer_done_d = 1'b1;
            if (layer_idx_q == LAST_LAYER) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              // Next layer starts straight away so busy never drops between layers.
              state_d     = CLR;
              acc_clr_d   = 1'b1;
              layer_idx_d = layer_idx_q + 4'd1;
            end
          end else begin
            wb_row_d = wb_row_q + 4'd1;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        feed_en_d   = 1'b0;
        feed_idx_d  = 4'd0;
        layer_idx_d = 4'd0;
        wb_valid_d  = 1'b0;
        wb_row_d    = 4'd0;
        drain_cnt_d = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      acc_clr_q    <= 1'b0;
      feed_en_q    <= 1'b0;
      feed_idx_q   <= 4'd0;
      layer_idx_q  <= 4'd0;
      wb_valid_q   <= 1'b0;
      wb_row_q     <= 4'd0;
      layer_done_q <= 1'b0;
      drain_cnt_q  <= 5'd0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      acc_clr_q    <= acc_clr_d;
      feed_en_q    <= feed_en_d;
      feed_idx_q   <= feed_idx_d;
      layer_idx_q  <= layer_idx_d;
      wb_valid_q   <= wb_valid_d;
      wb_row_q     <= wb_row_d;
      layer_done_q <= layer_done_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  assign layer_ctrl_busy = busy_q;
  assign acc_clr         = acc_clr_q;
  assign feed_en         = feed_en_q;
  assign feed_idx        = feed_idx_q;
  assign layer_idx       = layer_idx_q;
  assign wb_valid        = wb_valid_q;
  assign wb_row          = wb_row_q;
  assign layer_done      = layer_done_q;

endmodule

// File: tb/tb_layer_ctrl.sv
// Bench for layer_ctrl: a timeline model predicts every clear/feed/writeback/done event
// with its cycle stamp from the start edge and the pre-planned wb_ready pattern.
module tb_layer_ctrl;

  localparam int NL = 3;
  localparam int D  = 4;
  localparam int TAB = 4000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_layering;
  logic [2:0] mode;
  logic       wb_ready;
  logic       layer_ctrl_busy, acc_clr, feed_en, wb_valid, layer_done;
  logic [3:0] feed_idx, layer_idx, wb_row;

  logic       st6, rdy6;
  logic [2:0] md6;
  logic       b6, clr6, fe6, wv6, ld6;
  logic [3:0] fi6, li6, wr6;

  always #5 clk = ~clk;

  layer_ctrl #(.NUM_LAYERS(NL), .DIM(D)) dut (
    .clk(clk), .rst_n(rst_n), .start_layering(start_layering), .mode(mode),
    .wb_ready(wb_ready), .layer_ctrl_busy(layer_ctrl_busy), .acc_clr(acc_clr),
    .feed_en(feed_en), .feed_idx(feed_idx), .layer_idx(layer_idx),
    .wb_valid(wb_valid), .wb_row(wb_row), .layer_done(layer_done)
  );

  layer_ctrl #(.NUM_LAYERS(1), .DIM(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .start_layering(st6), .mode(md6),
    .wb_ready(rdy6), .layer_ctrl_busy(b6), .acc_clr(clr6),
    .feed_en(fe6), .feed_idx(fi6), .layer_idx(li6),
    .wb_valid(wv6), .wb_row(wr6), .layer_done(ld6)
  );

  typedef struct {
    int stamp;
    int layer;
    int idx;
  } ev_t;

  ev_t q_clr[$];
  ev_t q_feed[$];
  ev_t q_wb[$];
  ev_t q_done[$];
  ev_t ev_m;

  int  total = 0;
  int  bad = 0;
  int  ecount = 0;
  int  model_start = 0;
  int  model_end = 0;
  bit  ready_tab[0:TAB-1];
  int  cnt_busy, cnt_clr, cnt_feed, cnt_wb, cnt_done;
  int  c6_busy, c6_clr, c6_feed, c6_wb, c6_done;
  logic prev_b6 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, want, ecount);
    end
  endtask

  function automatic bit rdy(input int e);
    if (e >= 0 && e < TAB) return ready_tab[e];
    return 1'b1;
  endfunction

  function automatic logic [16:0] outs();
    return {layer_ctrl_busy, acc_clr, feed_en, feed_idx, layer_idx, wb_valid, wb_row, layer_done};
  endfunction

  // Timeline of one accepted sequence: CLR 1 cycle, FEED D cycles, DRAIN 2D-1 cycles,
  // then one row per cycle in which wb_ready is high.
  task automatic model_accept(input int e0);
    int e, edge_i, row, fin;
    e = e0;
    fin = e0;
    for (int l = 0; l < NL; l++) begin
      q_clr.push_back('{e, l, 0});
      for (int i = 0; i < D; i++) q_feed.push_back('{e + 1 + i, l, i});
      row = 0;
      edge_i = e + 3 * D + 1;
      while (row < D) begin
        if (rdy(edge_i)) begin
          q_wb.push_back('{edge_i - 1, l, row});
          row++;
          if (row == D) fin = edge_i;
        end
        edge_i++;
      end
      q_done.push_back('{fin, l, 0});
      e = fin;
    end
    model_start = e0;
    model_end   = fin;
  endtask

  task automatic step(input logic st, input logic [2:0] md);
    start_layering = st;
    mode = md;
    wb_ready = rdy(ecount + 1);
    if (st && md == 3'd2 && rst_n && (ecount + 1) > model_end) model_accept(ecount + 1);
    @(posedge clk);
    ecount++;
    #1;
    start_layering = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && ecount <= model_end; i++) step(1'b0, 3'd0);
    chk("idle_reached", (ecount > model_end), 1);
    chk("idle_busy", layer_ctrl_busy, 0);
    chk("queues_drained", q_clr.size() + q_feed.size() + q_wb.size() + q_done.size(), 0);
  endtask

  task automatic clear_counts();
    cnt_busy = 0; cnt_clr = 0; cnt_feed = 0; cnt_wb = 0; cnt_done = 0;
  endtask

  always @(negedge clk) begin
    chk("busy", layer_ctrl_busy, (ecount >= model_start && ecount < model_end));
    chk("feed_wb_excl", feed_en & wb_valid, 0);
    chk("clr_feed_excl", acc_clr & feed_en, 0);
    if (layer_ctrl_busy) cnt_busy++;
    if (acc_clr) begin
      cnt_clr++;
      if (q_clr.size() == 0) chk("clr_unexpected", 1, 0);
      else begin
        ev_m = q_clr.pop_front();
        chk("clr_time", ecount, ev_m.stamp);
        chk("clr_layer", layer_idx, ev_m.layer);
      end
    end
    if (feed_en) begin
      cnt_feed++;
      if (q_feed.size() == 0) chk("feed_unexpected", 1, 0);
      else begin
        ev_m = q_feed.pop_front();
        chk("feed_time", ecount, ev_m.stamp);
        chk("feed_layer", layer_idx, ev_m.layer);
        chk("feed_idx", feed_idx, ev_m.idx);
      end
    end
    if (wb_valid && wb_ready) begin
      cnt_wb++;
      if (q_wb.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        ev_m = q_wb.pop_front();
        chk("wb_time", ecount, ev_m.stamp);
        chk("wb_layer", layer_idx, ev_m.layer);
        chk("wb_row", wb_row, ev_m.idx);
      end
    end else if (wb_valid && q_wb.size() > 0) begin
      chk("wb_stall_row", wb_row, q_wb[0].idx);
      chk("wb_stall_layer", layer_idx, q_wb[0].layer);
    end
    if (layer_done) begin
      cnt_done++;
      if (q_done.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        ev_m = q_done.pop_front();
        chk("done_time", ecount, ev_m.stamp);
      end
    end
  end

  always @(negedge clk) begin
    if (b6) c6_busy++;
    if (clr6) c6_clr++;
    if (fe6) begin
      c6_feed++;
      chk("u6_feed_idx_range", (fi6 < 4'd2), 1);
    end
    if (wv6 && rdy6) begin
      c6_wb++;
      chk("u6_wb_row_range", (wr6 < 4'd2), 1);
    end
    if (b6) chk("u6_layer", li6, 0);
    if (ld6) begin
      c6_done++;
      chk("u6_done_on_fall", {prev_b6, b6}, 2'b10);
    end
    prev_b6 = b6;
  end

  initial begin
    int s;
    rst_n = 1'b0;
    start_layering = 1'b0;
    mode = 3'd0;
    wb_ready = 1'b1;
    st6 = 1'b0;
    md6 = 3'd2;
    rdy6 = 1'b1;
    c6_busy = 0; c6_clr = 0; c6_feed = 0; c6_wb = 0; c6_done = 0;
    for (int i = 0; i < TAB; i++) ready_tab[i] = 1'b1;
    clear_counts();

    step(1'b0, 3'd0);
    step(1'b0, 3'd0);
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;
    step(1'b0, 3'd0);

    // mode != LAYER start is ignored
    step(1'b1, 3'd1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 3'd0);
      chk("mode1_outs", outs(), 0);
    end

    // plain sequence, wb_ready always high
    clear_counts();
    step(1'b1, 3'd2);
    wait_idle();
    chk("s1_busy_len", cnt_busy, 48);
    chk("s1_clr_cnt", cnt_clr, 3);
    chk("s1_feed_cnt", cnt_feed, 12);
    chk("s1_wb_cnt", cnt_wb, 12);
    chk("s1_done_cnt", cnt_done, 3);

    // 5-cycle writeback stall while wb_row=2 of layer 0
    clear_counts();
    s = ecount + 1;
    for (int k = 15; k < 20; k++) ready_tab[s + k] = 1'b0;
    step(1'b1, 3'd2);
    wait_idle();
    chk("s3_busy_len", cnt_busy, 53);
    chk("s3_wb_cnt", cnt_wb, 12);

    // second start during FEED of layer 1
    clear_counts();
    step(1'b1, 3'd2);
    s = model_start;
    while (ecount < s + 18) step(1'b0, 3'd0);
    step(1'b1, 3'd2);
    wait_idle();
    chk("s4_busy_len", cnt_busy, 48);
    chk("s4_clr_cnt", cnt_clr, 3);
    chk("s4_done_cnt", cnt_done, 3);

    // random starts, modes and writeback back-pressure
    for (int i = ecount + 1; i < ecount + 1500 && i < TAB; i++) ready_tab[i] = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < 1200; i++)
      step(($urandom_range(0, 4) == 0), ($urandom_range(0, 1) != 0) ? 3'd2 : 3'($urandom_range(0, 7)));
    wait_idle();

    // reset during DRAIN of layer 1
    for (int i = ecount + 1; i < ecount + 300 && i < TAB; i++) ready_tab[i] = 1'b1;
    clear_counts();
    step(1'b1, 3'd2);
    s = model_start;
    while (ecount < s + 23) step(1'b0, 3'd0);
    rst_n = 1'b0;
    #1;
    chk("s5_reset_outs", outs(), 0);
    q_clr.delete(); q_feed.delete(); q_wb.delete(); q_done.delete();
    model_start = ecount;
    model_end = ecount;
    step(1'b0, 3'd0);
    step(1'b0, 3'd0);
    chk("s5_no_done", cnt_done, 1);
    rst_n = 1'b1;
    step(1'b0, 3'd0);
    clear_counts();
    step(1'b1, 3'd2);
    wait_idle();
    chk("s5_busy_len", cnt_busy, 48);
    chk("s5_done_cnt", cnt_done, 3);

    // single layer, DIM=2 instance
    st6 = 1'b1;
    step(1'b0, 3'd0);
    st6 = 1'b0;
    for (int i = 0; i < 15; i++) step(1'b0, 3'd0);
    chk("s6_busy_len", c6_busy, 8);
    chk("s6_clr_cnt", c6_clr, 1);
    chk("s6_feed_cnt", c6_feed, 2);
    chk("s6_wb_cnt", c6_wb, 2);
    chk("s6_done_cnt", c6_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
